// File: rtl/demux_1_3_buf_pkg.sv
// Shared definitions for the 1-to-3 buffered demultiplexer: widths, select codes
// and the saturating drop counter helper.
package demux_1_3_buf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DROP_CNT_W = 8;
    localparam int NUM_OUT    = 3;

    typedef enum logic [1:0] {
        SEL_OUT0 = 2'b00,
        SEL_OUT1 = 2'b01,
        SEL_OUT2 = 2'b10,
        SEL_INV  = 2'b11
    } sel_e;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/demux_1_3_buf_fifo2.sv
// Two-entry FIFO used as the per-output buffer. full/empty are registered
// views of the occupancy so upstream ready never depends on the consumer.
module demux_fifo2 #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
    // Head reads as zero when empty so the output bus is clean out of reset.
    assign head  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demux_1_3_buf.sv
// Routes each accepted word to one of three 2-deep output buffers by in_sel;
// words with the invalid code are dropped and counted.
module demux_1_3_buf
    import demux_1_3_buf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [1:0]            in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_W-1:0]     out0_data,
    output logic                  out0_valid,
    input  logic                  out0_ready,
    output logic [DATA_W-1:0]     out1_data,
    output logic                  out1_valid,
    input  logic                  out1_ready,
    output logic [DATA_W-1:0]     out2_data,
    output logic                  out2_valid,
    input  logic                  out2_ready,
    output logic                  err_drop,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; valid never waits on ready.

    sel_e                sel;
    logic                accept;
    logic                drop;
    logic [NUM_OUT-1:0]  push;
    logic [NUM_OUT-1:0]  pop;
    logic [NUM_OUT-1:0]  full;
    logic [NUM_OUT-1:0]  empty;
    logic [NUM_OUT-1:0]  out_ready;
    logic [DATA_W-1:0]   head [NUM_OUT];

    assign sel       = sel_e'(in_sel);
    assign out_ready = {out2_ready, out1_ready, out0_ready};

    // Ready looks only at the addressed buffer, so a stalled output never
    // blocks words bound elsewhere.
    always_comb begin
        in_ready = 1'b1;
        case (sel)
            SEL_OUT0: in_ready = ~full[0];
            SEL_OUT1: in_ready = ~full[1];
            SEL_OUT2: in_ready = ~full[2];
            SEL_INV:  in_ready = 1'b1;
            default:  in_ready = 1'b1;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign drop   = accept && (sel == SEL_INV);

    always_comb begin
        push = '0;
        if (accept) begin
            case (sel)
                SEL_OUT0: push[0] = 1'b1;
                SEL_OUT1: push[1] = 1'b1;
                SEL_OUT2: push[2] = 1'b1;
                default:  push    = '0;
            endcase
        end
    end

    assign pop = ~empty & out_ready;

    for (genvar n = 0; n < NUM_OUT; n++) begin : g_fifo
        demux_fifo2 #(
            .DATA_W(DATA_W)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (push[n]),
            .push_data(in_data),
            .pop      (pop[n]),
            .head     (head[n]),
            .full     (full[n]),
            .empty    (empty[n])
        );
    end

    assign out0_data  = head[0];
    assign out1_data  = head[1];
    assign out2_data  = head[2];
    assign out0_valid = ~empty[0];
    assign out1_valid = ~empty[1];
    assign out2_valid = ~empty[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_drop <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            err_drop <= 1'b1;
            drop_cnt <= sat_inc(drop_cnt);
        end
    end

endmodule

// File: tb/tb_demux_1_3_buf.sv
// Scoreboard bench for demux_1_3_buf: the driver queues expected words per
// output on acceptance, the monitor pops and compares on each delivery.
module tb_demux_1_3_buf;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  in_data = '0;
    logic [1:0]    in_sel = 2'b00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    ordy = 3'b111;
    logic [W-1:0]  od [3];
    logic [2:0]    ov;
    logic          err_drop;
    logic [7:0]    drop_cnt;

    logic [W-1:0]  exp_q [3][$];
    int            n_chk = 0;
    int            n_fail = 0;
    int            m_drops = 0;
    bit            m_err = 1'b0;
    bit            pend_v = 1'b0;
    logic [W-1:0]  pend_d;
    logic [1:0]    pend_s;
    logic [2:0]    nrdy = 3'b111;

    demux_1_3_buf #(.DATA_W(W)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out0_data(od[0]), .out0_valid(ov[0]), .out0_ready(ordy[0]),
        .out1_data(od[1]), .out1_valid(ov[1]), .out1_ready(ordy[1]),
        .out2_data(od[2]), .out2_valid(ov[2]), .out2_ready(ordy[2]),
        .err_drop(err_drop), .drop_cnt(drop_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // one clock of stimulus; the accepted word enters the model after the edge
    task automatic step(input bit v, input logic [W-1:0] d, input logic [1:0] s);
        bit exp_rdy;
        @(posedge clk);
        #1;
        if (pend_v) begin
            if (pend_s == 2'b11) begin
                m_err = 1'b1;
                if (m_drops < 255) m_drops++;
            end else begin
                exp_q[pend_s].push_back(pend_d);
            end
            pend_v = 1'b0;
        end
        in_valid = v;
        in_data  = d;
        in_sel   = s;
        ordy     = nrdy;
        #2;
        chk("err_drop", {31'd0, err_drop}, {31'd0, m_err});
        chk("drop_cnt", {24'd0, drop_cnt}, m_drops);
        if (v) begin
            exp_rdy = (s == 2'b11) || (exp_q[s].size() < 2);
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            if (in_ready) begin
                pend_v = 1'b1;
                pend_d = d;
                pend_s = s;
            end
        end
    endtask

    task automatic send(input logic [W-1:0] d, input logic [1:0] s);
        int tries = 0;
        do begin
            step(1'b1, d, s);
            tries++;
        end while (!pend_v && tries < 50);
        if (!pend_v) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 2'b00);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        for (int n = 0; n < 3; n++) begin
            chk("rst_valid", {31'd0, ov[n]}, 32'd0);
            chk("rst_data", od[n], 32'd0);
        end
        chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        chk("rst_err_drop", {31'd0, err_drop}, 32'd0);
        for (int n = 0; n < 3; n++) exp_q[n].delete();
        pend_v   = 1'b0;
        m_drops  = 0;
        m_err    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // monitor: compare every presented word against the head of its queue
    always @(negedge clk) begin
        if (!rst) begin
            for (int n = 0; n < 3; n++) begin
                chk("out_valid", {31'd0, ov[n]}, {31'd0, exp_q[n].size() > 0});
                if (ov[n] && exp_q[n].size() > 0) begin
                    chk("out_data", od[n], exp_q[n][0]);
                    if (ordy[n]) void'(exp_q[n].pop_front());
                end
            end
        end
    end

    initial begin
        #2;
        for (int n = 0; n < 3; n++) chk("init_valid", {31'd0, ov[n]}, 32'd0);
        chk("init_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        #10;
        rst = 1'b0;

        // basic routing
        nrdy = 3'b111;
        step(1'b1, 32'hA5A5_0001, 2'b00);
        step(1'b1, 32'h0000_0002, 2'b01);
        step(1'b1, 32'h0000_0003, 2'b10);
        idle(3);

        // backpressure on out1
        nrdy = 3'b101;
        send(32'h1111_0001, 2'b01);
        send(32'h1111_0002, 2'b01);
        step(1'b1, 32'h1111_0003, 2'b01);
        step(1'b1, 32'h1111_0003, 2'b01);
        nrdy = 3'b111;
        send(32'h1111_0003, 2'b01);
        idle(4);

        // out0 full and stalled, out2 still flows
        nrdy = 3'b110;
        send(32'h2222_0001, 2'b00);
        send(32'h2222_0002, 2'b00);
        step(1'b1, 32'h2222_0003, 2'b00);
        send(32'h2222_0004, 2'b10);
        idle(3);
        nrdy = 3'b111;
        idle(3);

        // invalid select
        repeat (3) send($urandom, 2'b11);
        idle(2);
        chk("drop_cnt_3", {24'd0, drop_cnt}, 32'd3);
        repeat (300) send($urandom, 2'b11);
        idle(2);
        chk("drop_cnt_sat", {24'd0, drop_cnt}, 32'hFF);

        // push and pop together on a one-entry buffer
        step(1'b1, 32'h3333_0001, 2'b10);
        step(1'b1, 32'h3333_0002, 2'b10);
        step(1'b1, 32'h3333_0003, 2'b10);
        idle(3);

        // asynchronous reset with buffers occupied
        nrdy = 3'b000;
        send(32'h4444_0001, 2'b00);
        send(32'h4444_0002, 2'b01);
        send(32'h4444_0003, 2'b10);
        send(32'h4444_0004, 2'b10);
        step(1'b1, 32'h4444_0005, 2'b11);
        async_reset();
        nrdy = 3'b111;
        step(1'b1, 32'h5555_0000, 2'b00);
        step(1'b1, 32'h5555_0001, 2'b01);
        step(1'b1, 32'h5555_0002, 2'b10);
        idle(3);

        // randomized traffic
        repeat (600) begin
            logic [1:0] s;
            nrdy = 3'($urandom);
            s = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            step($urandom_range(0, 3) != 0, $urandom, s);
        end
        nrdy = 3'b111;
        idle(4);

        // reset again in the middle of traffic
        nrdy = 3'b010;
        repeat (6) step(1'b1, $urandom, 2'($urandom_range(0, 3)));
        async_reset();
        nrdy = 3'b111;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_1_3_buf.md
DEMUX_1_3_BUF -- requirements
Module: demux_1_3_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 32, routed word width.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_data  input  DATA_W  word to route.
REQ-005 SHALL have port in_sel  input  2  destination code: 2'b00 -> out0, 2'b01 -> out1, 2'b10 -> out2, 2'b11 invalid.
REQ-006 SHALL have port in_valid  input  1  in_data and in_sel valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts the word this cycle.
REQ-008 SHALL have ports outN_data  output  DATA_W, outN_valid  output  1, outN_ready  input  1, for N = 0, 1, 2.
REQ-009 SHALL have port err_drop  output  1  sticky flag: an invalid-select word was dropped.
REQ-010 SHALL have port drop_cnt  output  8  count of dropped words, saturating.

Function
REQ-011 SHALL accept a word on a rising edge when in_valid=1 and in_ready=1.
REQ-012 SHALL hold one 2-entry FIFO per output; each FIFO preserves order among the words routed to it.
REQ-013 SHALL drive in_ready = ~fullN for in_sel = N (N = 0..2) and in_ready = 1 for in_sel = 2'b11; fullN is a register and does not depend on outN_ready.
REQ-014 SHALL present an accepted word on outN_valid/outN_data on the first cycle after acceptance, when FIFO N was empty (latency 1).
REQ-015 SHALL dequeue FIFO N on a rising edge when outN_valid=1 and outN_ready=1; outN_data shows the head entry.
REQ-016 SHALL hold outN_data stable while outN_valid=1 and outN_ready=0.
REQ-017 SHALL, on a simultaneous push and pop to a full FIFO N, refuse the push (in_ready=0) and perform the pop.
REQ-018 SHALL, on a simultaneous push and pop to FIFO N with one entry, perform both; occupancy stays 1.
REQ-019 SHALL leave the other two outputs unaffected by a stall on one output; there is no head-of-line blocking except for words addressed to the full FIFO.
REQ-020 SHALL discard an accepted word with in_sel=2'b11, set err_drop=1, and increment drop_cnt, saturating at 8'hFF.
REQ-021 SHALL keep err_drop at 1 until reset.
REQ-022 SHALL keep FIFO state and counters unchanged when in_valid=0.

Reset
REQ-023 SHALL, while rst=1, immediately force all FIFOs empty, outN_valid=0, outN_data=0, err_drop=0 and drop_cnt=0, independent of clk.
REQ-024 SHALL discard in-flight words on reset mid-operation, with no partial delivery after release.
REQ-025 SHALL drive in_ready=1 for all valid in_sel codes in the first cycle after reset release.

Structure
REQ-026 SHALL take DATA_W default, select codes (SEL_OUT0/1/2, SEL_INV) and the drop_cnt width from the shared processor package.
REQ-027 SHALL implement each buffer as sub-module demux_fifo2 (2-entry FIFO with push, pop, full, empty), instantiated three times.

Verification
REQ-028 Bench SHALL cover basic routing: push 32'hA5A5_0001 sel=00, 32'h0000_0002 sel=01, 32'h0000_0003 sel=10 with all ready=1 -> each word appears on out0/out1/out2 respectively, one cycle after its acceptance.
REQ-029 Bench SHALL cover backpressure: out1_ready=0 and three words pushed to sel=01 -> the first two are accepted, in_ready=0 on the third, out1_data is held at the first word; raise out1_ready -> words delivered in order.
REQ-030 Bench SHALL cover independence: out0 full and stalled, push to sel=10 -> accepted and delivered on out2 next cycle.
REQ-031 Bench SHALL cover invalid select: 3 pushes with sel=11 -> no outN_valid, err_drop=1, drop_cnt=3; 300 pushes -> drop_cnt=8'hFF.
REQ-032 Bench SHALL cover simultaneous push and pop: FIFO 2 holds 1 entry with out2_ready=1 while a new word is pushed -> occupancy stays 1 and both words are delivered in order.
REQ-033 Bench SHALL cover asynchronous reset: rst asserted between edges with FIFOs non-empty -> all outN_valid=0 and drop_cnt=0 before the next clk edge.
